// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch_debounce input conditioning block.
// Optional build macro: SWITCH_DEBOUNCE_INVERT_EN (see switch_debounce.sv).
package switch_debounce_pkg;

    // Short count for fast simulation; the long count suits ~10 ms at a 50 MHz board clock.
    localparam int SIM_DEBOUNCE_CYCLES   = 4;
    localparam int BOARD_DEBOUNCE_CYCLES = 500000;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Stability counter width; at least one bit so DEBOUNCE_CYCLES=1 still elaborates.
    function automatic int counter_width(input int cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

    localparam int SIM_COUNTER_WIDTH   = counter_width(SIM_DEBOUNCE_CYCLES);
    localparam int BOARD_COUNTER_WIDTH = counter_width(BOARD_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter, stable level
// and registered rise/fall strobes. SYNC_STAGES must be at least 2.
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
    input  logic clk_in,
    input  logic rst,
    input  logic pin,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic settling
);

    localparam int             CW         = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic                   stable_reg, stable_next;
    logic [CW-1:0]          count_reg, count_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    assign s = sync_reg[SYNC_STAGES-1];

    // Synchroniser chain: bit 0 samples the asynchronous pin, the top bit is s.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
        end
    end

    // Filter: accept s only after it has differed from the stable level on
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        stable_next = stable_reg;
        count_next  = count_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (s == stable_reg) begin
            count_next = '0;
        end else if (count_reg == LAST_COUNT) begin
            stable_next = s;
            count_next  = '0;
            rise_next   = s;
            fall_next   = ~s;
        end else begin
            count_next = count_reg + CW'(1);
        end
    end

    // Filter state and strobes; strobes line up with the clean level change.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            stable_reg <= 1'b0;
            count_reg  <= '0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            stable_reg <= stable_next;
            count_reg  <= count_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    assign clean    = stable_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign settling = (count_reg != '0);

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH slide switches / push buttons into clean levels plus
// one-cycle rise and fall strobes for the lab top-level.
// Optional build macro: SWITCH_DEBOUNCE_INVERT_EN inverts every raw pin before
// the synchroniser so active-low buttons read as 1 when pressed.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] settling
);

    logic [WIDTH-1:0] pin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_channel
`ifdef SWITCH_DEBOUNCE_INVERT_EN
            assign pin[gi] = ~raw_in[gi];
`else
            assign pin[gi] = raw_in[gi];
`endif
            debounce_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_channel (
                .clk_in   (clk_in),
                .rst      (rst),
                .pin      (pin[gi]),
                .clean    (clean_out[gi]),
                .rise     (rise_pulse[gi]),
                .fall     (fall_pulse[gi]),
                .settling (settling[gi])
            );
        end
    endgenerate

endmodule
